// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and widths for the SDRAM port arbiter slice.
package sdram_port_arbiter_pkg;

    localparam int unsigned SDRAM_ADDR_W = 25;
    localparam int unsigned SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_RD = 2'd1,
        ARB_GNT_WR = 2'd2
    } arb_state_t;

    // Width of the burst counter: must represent BURST_MAX itself.
    function automatic int unsigned burst_cnt_w(input int unsigned burst_max);
        return $clog2(burst_max) + 1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Writer, reader and Avalon slave-side signals bundled for the arbiter.
interface sdram_port_arbiter_if
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = SDRAM_ADDR_W,
    parameter int unsigned DATA_W = SDRAM_DATA_W
);
    // Writer
    logic              iWR_REQ;
    logic [ADDR_W-1:0] iWR_ADDR;
    logic [DATA_W-1:0] iWR_DATA;
    logic              oWR_WAIT;
    // Reader
    logic              iRD_REQ;
    logic [ADDR_W-1:0] iRD_ADDR;
    logic              oRD_WAIT;
    logic [DATA_W-1:0] oRD_DATA;
    logic              oRD_DATAVALID;
    // Avalon slave
    logic [ADDR_W-1:0] oAV_ADDR;
    logic [DATA_W-1:0] oAV_WRDATA;
    logic              oAV_READ_N;
    logic              oAV_WRITE_N;
    logic [DATA_W-1:0] iAV_RDDATA;
    logic              iAV_RDVALID;
    logic              iAV_WAIT;

    // Arbiter's view
    modport slave (
        input  iWR_REQ, iWR_ADDR, iWR_DATA, iRD_REQ, iRD_ADDR,
               iAV_RDDATA, iAV_RDVALID, iAV_WAIT,
        output oWR_WAIT, oRD_WAIT, oRD_DATA, oRD_DATAVALID,
               oAV_ADDR, oAV_WRDATA, oAV_READ_N, oAV_WRITE_N
    );

    // Environment's view (masters plus SDRAM controller)
    modport master (
        output iWR_REQ, iWR_ADDR, iWR_DATA, iRD_REQ, iRD_ADDR,
               iAV_RDDATA, iAV_RDVALID, iAV_WAIT,
        input  oWR_WAIT, oRD_WAIT, oRD_DATA, oRD_DATAVALID,
               oAV_ADDR, oAV_WRDATA, oAV_READ_N, oAV_WRITE_N
    );
endinterface

// File: rtl/sdram_pending_counter.sv
// Outstanding-read counter: up on accept, down on returned data,
// saturating at both ends with a sticky underflow flag.
module sdram_pending_counter #(
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [PEND_W-1:0] o_count,
    output logic              o_error
);

    logic [PEND_W-1:0] r_count;
    logic              r_error;

    // Count update; simultaneous inc/dec cancel, dec at zero flags an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            if (i_dec && (r_count == '0)) begin
                r_error <= 1'b1;
            end
            if (i_inc && !i_dec) begin
                if (r_count < PEND_W'(MAX_PENDING)) begin
                    r_count <= r_count + PEND_W'(1);
                end
            end else if (i_dec && !i_inc) begin
                if (r_count != '0) begin
                    r_count <= r_count - PEND_W'(1);
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_error = r_error;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of the SDRAM controller's Avalon-MM port:
// read-priority grant, burst cap for fairness, bounded outstanding reads.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = SDRAM_ADDR_W,
    parameter int unsigned DATA_W      = SDRAM_DATA_W,
    parameter int unsigned BURST_MAX   = 16,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned PEND_W      = 4
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    sdram_port_arbiter_if.slave       bus,
    output logic [PEND_W-1:0]         oPENDING,
    output logic                      oERROR
);

    localparam int unsigned CNT_W = burst_cnt_w(BURST_MAX);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;

    logic [PEND_W-1:0] w_pending;
    logic              w_error;
    logic              w_rd_room;
    logic              w_rd_issue;
    logic              w_rd_accept;
    logic              w_wr_accept;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_cap_hit;
    logic [CNT_W-1:0]  w_cnt_sat;

    logic [ADDR_W-1:0] w_av_addr;
    logic [DATA_W-1:0] w_av_wrdata;
    logic              w_av_read_n;
    logic              w_av_write_n;
    logic              w_wr_wait;
    logic              w_rd_wait;

    // Issue/accept qualifiers and burst-counter arithmetic.
    always_comb begin
        w_rd_room   = (w_pending < PEND_W'(MAX_PENDING));
        w_rd_issue  = (r_state == ARB_GNT_RD) && bus.iRD_REQ && w_rd_room;
        w_rd_accept = w_rd_issue && !bus.iAV_WAIT;
        w_wr_accept = (r_state == ARB_GNT_WR) && bus.iWR_REQ && !bus.iAV_WAIT;
        w_cnt_inc   = r_cnt + CNT_W'(1);
        w_cap_hit   = (w_cnt_inc == CNT_W'(BURST_MAX));
        w_cnt_sat   = (w_cnt_inc > CNT_W'(BURST_MAX - 1)) ? CNT_W'(BURST_MAX - 1) : w_cnt_inc;
    end

    // Grant FSM and burst counter; a grant only moves when its master drops
    // the request or completes an accepted command at the burst cap.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_cnt <= '0;
                    if (bus.iRD_REQ) begin
                        r_state <= ARB_GNT_RD;
                    end else if (bus.iWR_REQ) begin
                        r_state <= ARB_GNT_WR;
                    end
                end
                ARB_GNT_RD: begin
                    if (!bus.iRD_REQ) begin
                        r_state <= bus.iWR_REQ ? ARB_GNT_WR : ARB_IDLE;
                        r_cnt   <= '0;
                    end else if (w_rd_accept) begin
                        if (w_cap_hit && bus.iWR_REQ) begin
                            r_state <= ARB_GNT_WR;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_sat;
                        end
                    end
                end
                ARB_GNT_WR: begin
                    if (!bus.iWR_REQ) begin
                        r_state <= bus.iRD_REQ ? ARB_GNT_RD : ARB_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wr_accept) begin
                        if (w_cap_hit && bus.iRD_REQ) begin
                            r_state <= ARB_GNT_RD;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_sat;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Slave-side command and master stalls, driven from the current grant.
    always_comb begin
        w_av_addr    = '0;
        w_av_wrdata  = '0;
        w_av_read_n  = 1'b1;
        w_av_write_n = 1'b1;
        w_wr_wait    = 1'b1;
        w_rd_wait    = 1'b1;
        case (r_state)
            ARB_GNT_RD: begin
                w_av_read_n = !w_rd_issue;
                w_av_addr   = bus.iRD_ADDR;
                w_rd_wait   = bus.iAV_WAIT || !w_rd_issue;
            end
            ARB_GNT_WR: begin
                w_av_write_n = !bus.iWR_REQ;
                w_av_addr    = bus.iWR_ADDR;
                w_av_wrdata  = bus.iWR_DATA;
                w_wr_wait    = bus.iAV_WAIT;
            end
            default: begin
            end
        endcase
    end

    sdram_pending_counter #(
        .MAX_PENDING (MAX_PENDING),
        .PEND_W      (PEND_W)
    ) u_pending (
        .clk     (iCLK),
        .rst_n   (iRST_N),
        .i_inc   (w_rd_accept),
        .i_dec   (bus.iAV_RDVALID),
        .o_count (w_pending),
        .o_error (w_error)
    );

    assign bus.oAV_ADDR      = w_av_addr;
    assign bus.oAV_WRDATA    = w_av_wrdata;
    assign bus.oAV_READ_N    = w_av_read_n;
    assign bus.oAV_WRITE_N   = w_av_write_n;
    assign bus.oWR_WAIT      = w_wr_wait;
    assign bus.oRD_WAIT      = w_rd_wait;
    // Slave returns reads in order and only the reader consumes them.
    assign bus.oRD_DATA      = bus.iAV_RDDATA;
    assign bus.oRD_DATAVALID = bus.iAV_RDVALID;
    assign oPENDING          = w_pending;
    assign oERROR            = w_error;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (BURST_MAX=4, MAX_PENDING=8).
module tb_sdram_port_arbiter;
    import sdram_port_arbiter_pkg::*;

    localparam int unsigned ADDR_W      = SDRAM_ADDR_W;
    localparam int unsigned DATA_W      = SDRAM_DATA_W;
    localparam int unsigned BURST_MAX   = 4;
    localparam int unsigned MAX_PENDING = 8;
    localparam int unsigned PEND_W      = 4;

    logic              iCLK;
    logic              iRST_N;
    logic [PEND_W-1:0] oPENDING;
    logic              oERROR;

    int n_cmp;
    int n_err;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BURST_MAX   (BURST_MAX),
        .MAX_PENDING (MAX_PENDING),
        .PEND_W      (PEND_W)
    ) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .bus      (bus),
        .oPENDING (oPENDING),
        .oERROR   (oERROR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All idle-grant outputs at once.
    task automatic chk_idle(input string tag);
        chk({tag, ".read_n"},  32'(bus.oAV_READ_N),  32'(1));
        chk({tag, ".write_n"}, 32'(bus.oAV_WRITE_N), 32'(1));
        chk({tag, ".addr"},    32'(bus.oAV_ADDR),    32'(0));
        chk({tag, ".wrdata"},  32'(bus.oAV_WRDATA),  32'(0));
        chk({tag, ".wr_wait"}, 32'(bus.oWR_WAIT),    32'(1));
        chk({tag, ".rd_wait"}, 32'(bus.oRD_WAIT),    32'(1));
    endtask

    initial begin
        logic exp_rd;
        n_cmp = 0;
        n_err = 0;
        iRST_N          = 1'b0;
        bus.iWR_REQ     = 1'b0;
        bus.iWR_ADDR    = '0;
        bus.iWR_DATA    = '0;
        bus.iRD_REQ     = 1'b0;
        bus.iRD_ADDR    = '0;
        bus.iAV_RDDATA  = '0;
        bus.iAV_RDVALID = 1'b0;
        bus.iAV_WAIT    = 1'b0;
        tick();
        tick();
        iRST_N = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset.pending", 32'(oPENDING), 32'(0));
        chk("reset.error",   32'(oERROR),   32'(0));

        // Read stream fills the pending window.
        bus.iRD_REQ  = 1'b1;
        bus.iRD_ADDR = 25'd100;
        #1;
        chk("rd_lat.read_n", 32'(bus.oAV_READ_N), 32'(1));
        chk("rd_lat.rd_wait", 32'(bus.oRD_WAIT), 32'(1));
        tick();
        chk("rd_gnt.addr", 32'(bus.oAV_ADDR), 32'(100));
        chk("rd_gnt.rd_wait", 32'(bus.oRD_WAIT), 32'(0));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rd_fill%0d.pending", i), 32'(oPENDING), 32'(i));
            chk($sformatf("rd_fill%0d.read_n", i), 32'(bus.oAV_READ_N), 32'(0));
            tick();
        end
        chk("rd_full.pending", 32'(oPENDING), 32'(8));
        chk("rd_full.read_n", 32'(bus.oAV_READ_N), 32'(1));
        chk("rd_full.rd_wait", 32'(bus.oRD_WAIT), 32'(1));
        tick();
        chk("rd_full_hold.pending", 32'(oPENDING), 32'(8));
        chk("rd_full_hold.read_n", 32'(bus.oAV_READ_N), 32'(1));
        bus.iAV_RDVALID = 1'b1;
        bus.iAV_RDDATA  = 16'h1111;
        #1;
        chk("rd_ret.valid", 32'(bus.oRD_DATAVALID), 32'(1));
        chk("rd_ret.data", 32'(bus.oRD_DATA), 32'(16'h1111));
        tick();
        bus.iAV_RDVALID = 1'b0;
        #1;
        chk("rd_ret.pending", 32'(oPENDING), 32'(7));
        chk("rd_ret.read_n", 32'(bus.oAV_READ_N), 32'(0));
        tick();
        chk("rd_refill.pending", 32'(oPENDING), 32'(8));

        // Drain all eight.
        bus.iRD_REQ     = 1'b0;
        bus.iAV_RDVALID = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.iAV_RDVALID = 1'b0;
        #1;
        chk("drain1.pending", 32'(oPENDING), 32'(0));
        chk("drain1.error", 32'(oERROR), 32'(0));
        chk_idle("drain1");

        // Accept and return in the same cycle at pending=3.
        bus.iRD_REQ = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("same.pending_pre", 32'(oPENDING), 32'(3));
        bus.iAV_RDVALID = 1'b1;
        bus.iAV_RDDATA  = 16'hA5C3;
        #1;
        chk("same.data", 32'(bus.oRD_DATA), 32'(16'hA5C3));
        chk("same.valid", 32'(bus.oRD_DATAVALID), 32'(1));
        chk("same.read_n", 32'(bus.oAV_READ_N), 32'(0));
        tick();
        chk("same.pending_post", 32'(oPENDING), 32'(3));
        bus.iRD_REQ = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.iAV_RDVALID = 1'b0;
        #1;
        chk("drain2.pending", 32'(oPENDING), 32'(0));
        chk("drain2.error", 32'(oERROR), 32'(0));

        // Both masters requesting: 4 reads / 4 writes alternation.
        bus.iRD_REQ  = 1'b1;
        bus.iWR_REQ  = 1'b1;
        bus.iRD_ADDR = 25'd200;
        bus.iWR_ADDR = 25'd300;
        bus.iWR_DATA = 16'h1234;
        #1;
        chk("alt_idle.read_n", 32'(bus.oAV_READ_N), 32'(1));
        chk("alt_idle.write_n", 32'(bus.oAV_WRITE_N), 32'(1));
        tick();
        for (int k = 0; k < 16; k++) begin
            exp_rd = (((k / 4) % 2) == 0);
            chk($sformatf("alt%0d.read_n", k), 32'(bus.oAV_READ_N), 32'(!exp_rd));
            chk($sformatf("alt%0d.write_n", k), 32'(bus.oAV_WRITE_N), 32'(exp_rd));
            chk($sformatf("alt%0d.addr", k), 32'(bus.oAV_ADDR), exp_rd ? 32'(200) : 32'(300));
            tick();
        end
        chk("alt_end.pending", 32'(oPENDING), 32'(8));
        chk("alt_end.read_n", 32'(bus.oAV_READ_N), 32'(1));
        chk("alt_end.rd_wait", 32'(bus.oRD_WAIT), 32'(1));
        chk("alt_end.wr_wait", 32'(bus.oWR_WAIT), 32'(1));

        // Stalled write is never preempted by a waiting reader.
        bus.iRD_REQ = 1'b0;
        tick();
        bus.iRD_REQ  = 1'b1;
        bus.iAV_WAIT = 1'b1;
        bus.iWR_ADDR = 25'h1ABCDEF;
        bus.iWR_DATA = 16'hBEEF;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d.write_n", i), 32'(bus.oAV_WRITE_N), 32'(0));
            chk($sformatf("stall%0d.addr", i), 32'(bus.oAV_ADDR), 32'(25'h1ABCDEF));
            chk($sformatf("stall%0d.wrdata", i), 32'(bus.oAV_WRDATA), 32'(16'hBEEF));
            chk($sformatf("stall%0d.wr_wait", i), 32'(bus.oWR_WAIT), 32'(1));
            chk($sformatf("stall%0d.rd_wait", i), 32'(bus.oRD_WAIT), 32'(1));
            tick();
        end
        bus.iAV_WAIT = 1'b0;
        #1;
        chk("stall_rel.wr_wait", 32'(bus.oWR_WAIT), 32'(0));
        tick();
        chk("stall_rel.still_wr", 32'(bus.oAV_WRITE_N), 32'(0));

        // Return everything outstanding.
        bus.iWR_REQ     = 1'b0;
        bus.iRD_REQ     = 1'b0;
        bus.iAV_RDVALID = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.iAV_RDVALID = 1'b0;
        #1;
        chk("drain3.pending", 32'(oPENDING), 32'(0));
        chk("drain3.error", 32'(oERROR), 32'(0));

        // Underflow sets the sticky error.
        bus.iAV_RDVALID = 1'b1;
        tick();
        bus.iAV_RDVALID = 1'b0;
        #1;
        chk("uflow.error", 32'(oERROR), 32'(1));
        chk("uflow.pending", 32'(oPENDING), 32'(0));
        tick();
        tick();
        chk("uflow_sticky.error", 32'(oERROR), 32'(1));

        // Reset in the middle of a read stream at pending=5.
        bus.iRD_REQ  = 1'b1;
        bus.iRD_ADDR = 25'd50;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("mid.pending", 32'(oPENDING), 32'(5));
        chk("mid.error", 32'(oERROR), 32'(1));
        iRST_N = 1'b0;
        tick();
        chk_idle("midrst");
        chk("midrst.pending", 32'(oPENDING), 32'(0));
        chk("midrst.error", 32'(oERROR), 32'(0));
        iRST_N = 1'b1;
        tick();
        chk("post_rst.read_n", 32'(bus.oAV_READ_N), 32'(0));
        chk("post_rst.addr", 32'(bus.oAV_ADDR), 32'(50));

        bus.iRD_REQ = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
